// File: rtl/game_state_ctrl_if.sv
// Game-flow signal bundle: control inputs from input/collision logic, and the
// state/display outputs that go to the renderers.
interface game_state_ctrl_if #(
  parameter int LIVES_W = 3,
  parameter int LEVEL_W = 6
);
  logic               frame_tick;
  logic               start_btn;
  logic               pause_btn;
  logic               player_hit;
  logic               level_clear;
  logic [2:0]         state;
  logic               title_on;
  logic               play_en;
  logic               over_on;
  logic               level_load;
  logic [LIVES_W-1:0] lives;
  logic [LEVEL_W-1:0] level;

  modport master (
    output frame_tick, start_btn, pause_btn, player_hit, level_clear,
    input  state, title_on, play_en, over_on, level_load, lives, level
  );

  modport slave (
    input  frame_tick, start_btn, pause_btn, player_hit, level_clear,
    output state, title_on, play_en, over_on, level_load, lives, level
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Game flow FSM: TITLE -> READY -> PLAY -> DYING/CLEAR -> OVER, frame-timed phases.
// Optional pause support is compiled in with `define PAUSE_GAME_EN.
module game_state_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_W      = 3,
  parameter int LEVEL_W      = 6,
  parameter int READY_FRAMES = 120,
  parameter int DEATH_FRAMES = 90,
  parameter int CLEAR_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic              Clk,
  input  logic              Reset_n,
  game_state_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_CLEAR = 3'd4,
    S_OVER  = 3'd5,
    S_PAUSE = 3'd6
  } state_t;

  localparam int MAX_RD = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
  localparam int MAX_CO = (CLEAR_FRAMES > OVER_FRAMES)  ? CLEAR_FRAMES : OVER_FRAMES;
  localparam int MAX_F  = (MAX_RD > MAX_CO) ? MAX_RD : MAX_CO;
  localparam int TMR_W  = $clog2(MAX_F + 1);

  localparam logic [TMR_W-1:0] READY_T = TMR_W'(READY_FRAMES);
  localparam logic [TMR_W-1:0] DEATH_T = TMR_W'(DEATH_FRAMES);
  localparam logic [TMR_W-1:0] CLEAR_T = TMR_W'(CLEAR_FRAMES);
  localparam logic [TMR_W-1:0] OVER_T  = TMR_W'(OVER_FRAMES);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               title_on_q, title_on_d;
  logic               play_en_q, play_en_d;
  logic               over_on_q, over_on_d;
  logic               level_load_q, level_load_d;
  logic               start_prev_q, start_prev_d;
  logic               start_edge;
  logic               pause_xfer;

`ifdef PAUSE_GAME_EN
  logic pause_prev_q, pause_prev_d;
  logic pause_edge;
  assign pause_prev_d = bus.pause_btn;
  assign pause_edge   = bus.pause_btn & ~pause_prev_q;
`else
  logic unused_pause;
  assign unused_pause = bus.pause_btn;
`endif

  assign start_prev_d = bus.start_btn;
  assign start_edge   = bus.start_btn & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    level_load_d = 1'b0;
    pause_xfer   = 1'b0;
    timer_d      = timer_q;
    if (bus.frame_tick && (timer_q != '1)) timer_d = timer_q + TMR_W'(1);

    case (state_q)
      S_TITLE: if (start_edge) begin
        state_d      = S_READY;
        lives_d      = LIVES_W'(LIVES_INIT);
        level_d      = LEVEL_W'(1);
        level_load_d = 1'b1;
      end
      S_READY: if (timer_q == READY_T) state_d = S_PLAY;
      S_PLAY: begin
        if (bus.player_hit)       state_d = S_DYING;
        else if (bus.level_clear) state_d = S_CLEAR;
`ifdef PAUSE_GAME_EN
        else if (pause_edge) begin
          state_d    = S_PAUSE;
          pause_xfer = 1'b1;
        end
`endif
      end
      S_DYING: if (timer_q == DEATH_T) begin
        if (lives_q == LIVES_W'(1)) begin
          state_d = S_OVER;
          lives_d = '0;
        end else begin
          state_d      = S_READY;
          lives_d      = lives_q - LIVES_W'(1);
          level_load_d = 1'b1;
        end
      end
      S_CLEAR: if (timer_q == CLEAR_T) begin
        state_d      = S_READY;
        level_load_d = 1'b1;
        if (level_q != '1) level_d = level_q + LEVEL_W'(1);
      end
      S_OVER: if (timer_q == OVER_T) state_d = S_TITLE;
`ifdef PAUSE_GAME_EN
      S_PAUSE: begin
        // Timer frozen while paused so the game resumes exactly where it stopped.
        timer_d = timer_q;
        if (pause_edge) begin
          state_d    = S_PLAY;
          pause_xfer = 1'b1;
        end
      end
`endif
      default: state_d = S_TITLE;
    endcase

    if ((state_d != state_q) && !pause_xfer) timer_d = '0;

    title_on_d = (state_d == S_TITLE);
    play_en_d  = (state_d == S_PLAY);
    over_on_d  = (state_d == S_OVER);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_TITLE;
      timer_q      <= '0;
      lives_q      <= '0;
      level_q      <= '0;
      title_on_q   <= 1'b1;
      play_en_q    <= 1'b0;
      over_on_q    <= 1'b0;
      level_load_q <= 1'b0;
      // Edge regs start high so a button already held at reset never fires.
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      title_on_q   <= title_on_d;
      play_en_q    <= play_en_d;
      over_on_q    <= over_on_d;
      level_load_q <= level_load_d;
      start_prev_q <= start_prev_d;
    end
  end

`ifdef PAUSE_GAME_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pause_prev_q <= 1'b1;
    else          pause_prev_q <= pause_prev_d;
  end
`endif

  assign bus.state      = state_q;
  assign bus.title_on   = title_on_q;
  assign bus.play_en    = play_en_q;
  assign bus.over_on    = over_on_q;
  assign bus.level_load = level_load_q;
  assign bus.lives      = lives_q;
  assign bus.level      = level_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: short phase timings, 2-bit level counter.
module tb_game_state_ctrl;
  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 2;

  logic Clk;
  logic Reset_n;
  int   tests;
  int   fails;

  game_state_ctrl_if #(.LIVES_W(LIVES_W), .LEVEL_W(LEVEL_W)) f();

  game_state_ctrl #(
    .LIVES_INIT(3), .LIVES_W(LIVES_W), .LEVEL_W(LEVEL_W),
    .READY_FRAMES(2), .DEATH_FRAMES(3), .CLEAR_FRAMES(2), .OVER_FRAMES(4)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(f.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    f.frame_tick = 1'b1;
    step();
    f.frame_tick = 1'b0;
  endtask

  // READY (just entered) -> PLAY
  task automatic go_play();
    frame(); frame(); step();
  endtask

  // PLAY -> DYING -> end of death phase
  task automatic die();
    f.player_hit = 1'b1; step(); f.player_hit = 1'b0;
    frame(); frame(); frame(); step();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; f.start_btn = 1'b1;
    step(2);
    tests++; if (f.state !== 3'd0) begin fails++; $display("FAIL rst_state got=%0d exp=0", f.state); end
    tests++; if ({f.title_on, f.play_en, f.over_on, f.level_load} !== 4'b1000) begin fails++; $display("FAIL rst_flags got=%b exp=1000", {f.title_on, f.play_en, f.over_on, f.level_load}); end
    tests++; if ({f.lives, f.level} !== '0) begin fails++; $display("FAIL rst_cnt lives=%0d level=%0d exp=0/0", f.lives, f.level); end
    Reset_n = 1'b1;
    step(3);
    tests++; if (f.state !== 3'd0) begin fails++; $display("FAIL held_start state=%0d exp=0", f.state); end
    f.start_btn = 1'b0; step();
    f.start_btn = 1'b1; step();
    tests++; if (f.state !== 3'd1) begin fails++; $display("FAIL start state=%0d exp=1", f.state); end
    tests++; if ({f.lives, f.level, f.level_load, f.title_on} !== {3'd3, 2'd1, 1'b1, 1'b0}) begin fails++; $display("FAIL start_vals lives=%0d level=%0d load=%b title=%b exp=3/1/1/0", f.lives, f.level, f.level_load, f.title_on); end
    f.start_btn = 1'b0; step();
    tests++; if (f.level_load !== 1'b0) begin fails++; $display("FAIL load_pulse got=%b exp=0", f.level_load); end
  endtask

  task automatic test_ready_play();
    frame(); frame();
    tests++; if (f.state !== 3'd1) begin fails++; $display("FAIL ready_hold state=%0d exp=1", f.state); end
    step();
    tests++; if ({f.state, f.play_en} !== {3'd2, 1'b1}) begin fails++; $display("FAIL play state=%0d play_en=%b exp=2/1", f.state, f.play_en); end
  endtask

  task automatic test_hit_priority();
    f.player_hit = 1'b1; f.level_clear = 1'b1; step();
    f.player_hit = 1'b0; f.level_clear = 1'b0;
    tests++; if ({f.state, f.play_en, f.level, f.lives} !== {3'd3, 1'b0, 2'd1, 3'd3}) begin fails++; $display("FAIL hit_prio state=%0d play_en=%b level=%0d lives=%0d exp=3/0/1/3", f.state, f.play_en, f.level, f.lives); end
  endtask

  task automatic test_deaths();
    frame(); frame(); frame();
    tests++; if (f.state !== 3'd3) begin fails++; $display("FAIL dying_hold state=%0d exp=3", f.state); end
    step();
    tests++; if ({f.state, f.lives, f.level_load} !== {3'd1, 3'd2, 1'b1}) begin fails++; $display("FAIL death1 state=%0d lives=%0d load=%b exp=1/2/1", f.state, f.lives, f.level_load); end
    go_play(); die();
    tests++; if ({f.state, f.lives} !== {3'd1, 3'd1}) begin fails++; $display("FAIL death2 state=%0d lives=%0d exp=1/1", f.state, f.lives); end
    go_play(); die();
    tests++; if ({f.state, f.lives, f.over_on, f.level_load} !== {3'd5, 3'd0, 1'b1, 1'b0}) begin fails++; $display("FAIL death3 state=%0d lives=%0d over=%b load=%b exp=5/0/1/0", f.state, f.lives, f.over_on, f.level_load); end
    frame(); frame(); frame(); frame();
    tests++; if (f.state !== 3'd5) begin fails++; $display("FAIL over_hold state=%0d exp=5", f.state); end
    step();
    tests++; if ({f.state, f.title_on, f.over_on, f.level} !== {3'd0, 1'b1, 1'b0, 2'd1}) begin fails++; $display("FAIL title state=%0d title=%b over=%b level=%0d exp=0/1/0/1", f.state, f.title_on, f.over_on, f.level); end
    f.player_hit = 1'b1; step(2); f.player_hit = 1'b0;
    tests++; if (f.state !== 3'd0) begin fails++; $display("FAIL hit_in_title state=%0d exp=0", f.state); end
  endtask

  task automatic test_level_sat();
    f.start_btn = 1'b1; step(); f.start_btn = 1'b0;
    for (int lv = 1; lv <= 3; lv++) begin
      go_play();
      f.level_clear = 1'b1; step(); f.level_clear = 1'b0;
      tests++; if (f.state !== 3'd4) begin fails++; $display("FAIL clear_enter lv=%0d state=%0d exp=4", lv, f.state); end
      frame(); frame(); step();
      tests++; if ({f.state, f.level, f.level_load} !== {3'd1, 2'((lv < 3) ? lv + 1 : 3), 1'b1}) begin fails++; $display("FAIL clear_exit lv=%0d state=%0d level=%0d load=%b exp=1/%0d/1", lv, f.state, f.level, f.level_load, (lv < 3) ? lv + 1 : 3); end
    end
  endtask

  task automatic test_async_reset();
    go_play();
    f.player_hit = 1'b1; step(); f.player_hit = 1'b0;
    frame(); frame();
    #2 Reset_n = 1'b0;
    #1;
    tests++; if ({f.state, f.title_on, f.play_en, f.over_on, f.level_load} !== {3'd0, 4'b1000}) begin fails++; $display("FAIL async_flags state=%0d flags=%b exp=0/1000", f.state, {f.title_on, f.play_en, f.over_on, f.level_load}); end
    tests++; if ({f.lives, f.level} !== '0) begin fails++; $display("FAIL async_cnt lives=%0d level=%0d exp=0/0", f.lives, f.level); end
    step(2);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if ({f.state, f.level_load} !== {3'd0, 1'b0}) begin fails++; $display("FAIL post_rst cyc=%0d state=%0d load=%b exp=0/0", i, f.state, f.level_load); end
    end
  endtask

  task automatic test_pause();
    f.start_btn = 1'b1; step(); f.start_btn = 1'b0;
    go_play();
    f.pause_btn = 1'b1; step(); f.pause_btn = 1'b0;
`ifdef PAUSE_GAME_EN
    tests++; if ({f.state, f.play_en} !== {3'd6, 1'b0}) begin fails++; $display("FAIL pause_enter state=%0d play_en=%b exp=6/0", f.state, f.play_en); end
    f.player_hit = 1'b1; step(); f.player_hit = 1'b0;
    tests++; if (f.state !== 3'd6) begin fails++; $display("FAIL pause_hit state=%0d exp=6", f.state); end
    f.pause_btn = 1'b1; step(); f.pause_btn = 1'b0;
    tests++; if ({f.state, f.play_en} !== {3'd2, 1'b1}) begin fails++; $display("FAIL pause_exit state=%0d play_en=%b exp=2/1", f.state, f.play_en); end
`else
    tests++; if ({f.state, f.play_en} !== {3'd2, 1'b1}) begin fails++; $display("FAIL no_pause state=%0d play_en=%b exp=2/1", f.state, f.play_en); end
`endif
  endtask

  initial begin
    tests = 0; fails = 0;
    Reset_n = 1'b0;
    f.frame_tick = 1'b0; f.start_btn = 1'b1; f.pause_btn = 1'b0;
    f.player_hit = 1'b0; f.level_clear = 1'b0;
    test_reset();
    test_ready_play();
    test_hit_priority();
    test_deaths();
    test_level_sat();
    test_async_reset();
    test_pause();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
